// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode-hazard types: forwarding select encoding, register index and stage indices.
package hazard_scoreboard_pkg;

  typedef logic [4:0] regidx_t;

  typedef enum logic [2:0] {
    FwdNone  = 3'd0,
    FwdAluE  = 3'd1,
    FwdAluM  = 3'd2,
    FwdResW  = 3'd3,
    FwdMulti = 3'd4
  } hazard_forward_t;

  localparam int unsigned StageE    = 0;
  localparam int unsigned StageM    = 1;
  localparam int unsigned StageW    = 2;
  localparam int unsigned NumStages = 3;

endpackage

// File: rtl/hazard_port_eval.sv
// Per-source-port forwarding select and stall contribution (purely combinational).
// HAZARD_BRANCH_FWD_EN enables E/M forwarding into decode for branch operands.
module hazard_port_eval
  import hazard_scoreboard_pkg::*;
(
  input  logic                       valid,
  input  regidx_t                    idx,
  input  logic                       branch,
  input  logic [NumStages-1:0]       wen,
  input  regidx_t [NumStages-1:0]    dst,
  input  logic                       load_e,
  input  logic                       load_m,
  input  logic                       pend_busy,
  input  regidx_t                    pend_dst,
  input  logic                       multi_done,
  output hazard_forward_t            sel,
  output logic                       stall
);

  logic live;
  logic hit_e;
  logic hit_m;
  logic hit_w;
  logic hit_p;

  assign live  = valid & (idx != '0);
  assign hit_e = wen[StageE] & (dst[StageE] == idx);
  assign hit_m = wen[StageM] & (dst[StageM] == idx);
  assign hit_w = wen[StageW] & (dst[StageW] == idx);
  assign hit_p = pend_busy & (pend_dst == idx);

  always_comb begin
    sel   = FwdNone;
    stall = 1'b0;
    if (live) begin
      if (branch) begin
`ifdef HAZARD_BRANCH_FWD_EN
        if (hit_e & ~load_e) begin
          sel = FwdAluE;
        end else if (hit_m & ~load_m) begin
          sel = FwdAluM;
        end else if (hit_w) begin
          sel = FwdResW;
        end
        stall = hit_m & load_m;
`else
        // Without decode-side E/M paths, any younger in-flight writer blocks the compare.
        if (hit_w) begin
          sel = FwdResW;
        end
        stall = hit_e | hit_m;
`endif
      end else if (hit_w) begin
        sel = FwdResW;
      end
      if (hit_p & multi_done) begin
        sel = FwdMulti;
      end
      stall = stall | (hit_e & load_e) | (hit_p & ~multi_done);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode hazard unit: NREAD-port forwarding/stall plus a one-entry multi-cycle scoreboard.
// Build option HAZARD_BRANCH_FWD_EN selects decode-stage E/M forwarding for branches.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREAD = 2,
  parameter int unsigned LATW  = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREAD-1:0]   src_valid_d,
  input  logic [NREAD*5-1:0] src_idx_d,
  input  logic               branch_d,
  input  logic               issue_d,
  input  logic               issue_multi_d,
  input  logic [4:0]         issue_dst_d,
  input  logic [LATW-1:0]    issue_lat_d,
  input  logic               wen_e,
  input  logic               wen_m,
  input  logic               wen_w,
  input  logic [4:0]         dst_e,
  input  logic [4:0]         dst_m,
  input  logic [4:0]         dst_w,
  input  logic               load_e,
  input  logic               load_m,
  input  logic               flush,
  output logic [NREAD*3-1:0] fwd_sel_d,
  output logic               stall_d,
  output logic               multi_busy,
  output logic               multi_done
);

  typedef enum logic [0:0] {StIdle, StBusy} sb_state_e;

  sb_state_e       state_q, state_d;
  regidx_t         dst_q, dst_d;
  logic [LATW-1:0] cnt_q, cnt_d;

  logic [NumStages-1:0]    wen_vec;
  regidx_t [NumStages-1:0] dst_vec;
  logic [NREAD-1:0]        port_stall;
  hazard_forward_t         port_sel [NREAD];
  logic                    struct_stall;
  logic                    issue_multi;

  assign wen_vec[StageE] = wen_e;
  assign wen_vec[StageM] = wen_m;
  assign wen_vec[StageW] = wen_w;
  assign dst_vec[StageE] = dst_e;
  assign dst_vec[StageM] = dst_m;
  assign dst_vec[StageW] = dst_w;

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    hazard_port_eval u_eval (
      .valid      (src_valid_d[i]),
      .idx        (src_idx_d[5*i +: 5]),
      .branch     (branch_d),
      .wen        (wen_vec),
      .dst        (dst_vec),
      .load_e     (load_e),
      .load_m     (load_m),
      .pend_busy  (multi_busy),
      .pend_dst   (dst_q),
      .multi_done (multi_done),
      .sel        (port_sel[i]),
      .stall      (port_stall[i])
    );
    assign fwd_sel_d[3*i +: 3] = port_sel[i];
  end

  // The unit accepts a new op only once the current one is in its done cycle.
  assign struct_stall = issue_multi_d & multi_busy & ~multi_done;
  assign stall_d      = (|port_stall) | struct_stall;
  assign issue_multi  = issue_d & issue_multi_d & ~stall_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (issue_multi) begin
      state_d = StBusy;
      dst_d   = issue_dst_d;
      cnt_d   = issue_lat_d;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - LATW'(1);
      if (cnt_q == LATW'(1)) begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    multi_busy = (state_q == StBusy);
    multi_done = (state_q == StBusy) && (cnt_q == LATW'(1));
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed checks of hazard_scoreboard against a cycle-stamped reference model.
module tb_hazard_scoreboard;

  localparam int NREAD = 2;
  localparam int LATW  = 6;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREAD-1:0]   src_valid_d;
  logic [NREAD*5-1:0] src_idx_d;
  logic               branch_d, issue_d, issue_multi_d;
  logic [4:0]         issue_dst_d;
  logic [LATW-1:0]    issue_lat_d;
  logic               wen_e, wen_m, wen_w;
  logic [4:0]         dst_e, dst_m, dst_w;
  logic               load_e, load_m, flush;
  logic [NREAD*3-1:0] fwd_sel_d;
  logic               stall_d, multi_busy, multi_done;

  hazard_scoreboard #(.NREAD(NREAD), .LATW(LATW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .src_valid_d   (src_valid_d),
    .src_idx_d     (src_idx_d),
    .branch_d      (branch_d),
    .issue_d       (issue_d),
    .issue_multi_d (issue_multi_d),
    .issue_dst_d   (issue_dst_d),
    .issue_lat_d   (issue_lat_d),
    .wen_e         (wen_e),
    .wen_m         (wen_m),
    .wen_w         (wen_w),
    .dst_e         (dst_e),
    .dst_m         (dst_m),
    .dst_w         (dst_w),
    .load_e        (load_e),
    .load_m        (load_m),
    .flush         (flush),
    .fwd_sel_d     (fwd_sel_d),
    .stall_d       (stall_d),
    .multi_busy    (multi_busy),
    .multi_done    (multi_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: the pending op is described by its destination and the absolute
  // cycle number at which its result appears.
  int          cyc;
  bit          m_busy;
  logic [4:0]  m_dst;
  int          m_done_at;
  logic [2:0]  exp_sel [NREAD];
  bit          exp_stall;
  bit          exp_done;

  task automatic model_eval();
    bit em, mm, wm, pm, live, st;
    logic [4:0] idx;
    logic [2:0] sel;
    exp_done  = m_busy && (cyc == m_done_at);
    exp_stall = issue_multi_d && m_busy && !exp_done;
    for (int i = 0; i < NREAD; i++) begin
      idx  = src_idx_d[5*i +: 5];
      live = src_valid_d[i] && (idx != 5'd0);
      em   = wen_e && (dst_e == idx);
      mm   = wen_m && (dst_m == idx);
      wm   = wen_w && (dst_w == idx);
      pm   = m_busy && (m_dst == idx);
      sel  = 3'd0;
      st   = 1'b0;
      if (live) begin
        if (branch_d) begin
`ifdef HAZARD_BRANCH_FWD_EN
          if (em && !load_e) sel = 3'd1;
          else if (mm && !load_m) sel = 3'd2;
          else if (wm) sel = 3'd3;
          st = mm && load_m;
`else
          if (wm) sel = 3'd3;
          st = em || mm;
`endif
        end else if (wm) sel = 3'd3;
        if (pm && exp_done) sel = 3'd4;
        st = st || (em && load_e) || (pm && !exp_done);
      end
      exp_sel[i] = sel;
      exp_stall  = exp_stall || st;
    end
  endtask

  task automatic model_update();
    if (flush) m_busy = 1'b0;
    else if (issue_d && issue_multi_d && !exp_stall) begin
      m_busy    = 1'b1;
      m_dst     = issue_dst_d;
      m_done_at = cyc + int'(issue_lat_d);
    end else if (exp_done) m_busy = 1'b0;
    cyc++;
  endtask

  task automatic eval_check();
    #1;
    model_eval();
    for (int i = 0; i < NREAD; i++) check($sformatf("sel%0d", i), 32'(fwd_sel_d[3*i +: 3]), 32'(exp_sel[i]));
    check("stall", 32'(stall_d), 32'(exp_stall));
    check("busy", 32'(multi_busy), 32'(m_busy));
    check("done", 32'(multi_done), 32'(exp_done));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    src_valid_d = '0; src_idx_d = '0; branch_d = 0; issue_d = 0; issue_multi_d = 0;
    issue_dst_d = '0; issue_lat_d = '0; wen_e = 0; wen_m = 0; wen_w = 0;
    dst_e = '0; dst_m = '0; dst_w = '0; load_e = 0; load_m = 0; flush = 0;
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    cyc = 0; m_busy = 0; m_dst = '0; m_done_at = 0;
    #1;
    check("rst_busy", 32'(multi_busy), 32'd0);
    check("rst_done", 32'(multi_done), 32'd0);
    check("rst_stall", 32'(stall_d), 32'd0);
    check("rst_fwd", 32'(fwd_sel_d), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Load-use, then the load moves to M.
    src_valid_d = 2'b01; src_idx_d[4:0] = 5'd8; wen_e = 1; dst_e = 5'd8; load_e = 1;
    eval_check();
    check("lu_stall", 32'(stall_d), 32'd1);
    check("lu_sel", 32'(fwd_sel_d[2:0]), 32'd0);
    advance();
    wen_e = 0; load_e = 0; wen_m = 1; dst_m = 5'd8; load_m = 1;
    eval_check();
    check("lu_next", 32'(stall_d), 32'd0);
    advance();

    // Multi-cycle op, latency 4, dst r9; reader stalls 3 cycles then gets MULTI.
    clear_inputs();
    issue_d = 1; issue_multi_d = 1; issue_dst_d = 5'd9; issue_lat_d = 6'd4;
    eval_check();
    advance();
    clear_inputs();
    src_valid_d = 2'b10; src_idx_d[9:5] = 5'd9;
    for (int k = 0; k < 3; k++) begin
      eval_check();
      check("mc_wait", 32'(stall_d), 32'd1);
      advance();
    end
    eval_check();
    check("mc_sel", 32'(fwd_sel_d[5:3]), 32'd4);
    check("mc_done", 32'(multi_done), 32'd1);
    advance();
    eval_check();
    check("mc_idle", 32'(multi_busy), 32'd0);
    advance();

    // Flush at counter 2 with a simultaneous issue.
    clear_inputs();
    issue_d = 1; issue_multi_d = 1; issue_dst_d = 5'd5; issue_lat_d = 6'd4;
    eval_check(); advance();
    issue_d = 0; issue_multi_d = 0;
    eval_check(); advance();
    eval_check(); advance();
    issue_d = 1; issue_multi_d = 1; issue_dst_d = 5'd6; issue_lat_d = 6'd3; flush = 1;
    eval_check(); advance();
    clear_inputs();
    eval_check();
    check("fl_busy", 32'(multi_busy), 32'd0);
    check("fl_done", 32'(multi_done), 32'd0);
    advance();

    // Randomised traffic over a small register pool so hazards are frequent.
    for (int c = 0; c < 1500; c++) begin
      src_valid_d   = NREAD'($urandom);
      for (int i = 0; i < NREAD; i++) src_idx_d[5*i +: 5] = 5'($urandom_range(0, 3));
      branch_d      = ($urandom_range(0, 2) == 0);
      issue_d       = ($urandom_range(0, 1) == 0);
      issue_multi_d = ($urandom_range(0, 2) == 0);
      issue_dst_d   = 5'($urandom_range(0, 3));
      issue_lat_d   = 6'($urandom_range(1, 5));
      wen_e = $urandom_range(0, 1) == 0; dst_e = 5'($urandom_range(0, 3));
      wen_m = $urandom_range(0, 1) == 0; dst_m = 5'($urandom_range(0, 3));
      wen_w = $urandom_range(0, 1) == 0; dst_w = 5'($urandom_range(0, 3));
      load_e = $urandom_range(0, 2) == 0;
      load_m = $urandom_range(0, 2) == 0;
      flush  = $urandom_range(0, 15) == 0;
      eval_check();
      advance();
    end

    // Asynchronous reset while busy drops the entry at once.
    clear_inputs();
    issue_d = 1; issue_multi_d = 1; issue_dst_d = 5'd7; issue_lat_d = 6'd5;
    eval_check(); advance();
    clear_inputs();
    src_valid_d = 2'b01; src_idx_d[4:0] = 5'd0;
    eval_check();
    check("r0_sel", 32'(fwd_sel_d[2:0]), 32'd0);
    check("pre_rst_busy", 32'(multi_busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", 32'(multi_busy), 32'd0);
    check("arst_done", 32'(multi_done), 32'd0);
    m_busy = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    eval_check();
    advance();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
